lmsm_expander: RTL and testbench
================================

# lmsm_expander

Front-end sequencer between fetch and the decode stage. Accepts one 16-bit instruction at a time and passes ordinary instructions through a one-entry output register. Expands each LM/SM multiple-register instruction into a stream of single LW/SW micro-instructions in the same encoding the decoder consumes, stalling fetch until the expansion completes.

## Interface
- ADDR_STRIDE, 2: address increment between consecutive transferred registers. Legal range is 1..3.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous. Abandons any expansion and drops the output register.
- in_valid  in  1  in_inst is valid.
- in_inst  in  16  fetched instruction.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- out_valid  out  1  out_inst is valid.
- out_inst  out  16  instruction to decode.
- out_ready  in  1  decode accepts when out_valid && out_ready.
- out_last  out  1  out_inst is the final instruction of its originating fetch word. It is 1 for pass-through instructions.
- busy  out  1  expansion in progress; fetch holds the PC.

## Operation
- Field map: op=[15:12], RA=[11:9], RB=[8:6], imm6=[5:0], mask=[7:0]. LW=0100, SW=0101, LM=0110, SM=0111, ADI=0000 with destination in RB.
- An output slot is free when !out_valid || out_ready.
- in_ready = (state==IDLE) && slot free && !flush.
- State machine:
  - IDLE, accepting a non-LM/SM instruction: out_inst <= in_inst, out_valid <= 1, out_last <= 1.
  - IDLE, accepting LM/SM with mask==0: the instruction is consumed and no output is produced.
  - IDLE, accepting LM/SM with mask!=0: latch base RA, kind, orig_mask, and pend_mask=orig_mask, then go to EXPAND. Whether RA is in the mask is evaluated only for LM.
- EXPAND, on each cycle with a free slot, emit one micro-op:
  - Selection: lowest set bit i of pend_mask, then clear it. For LM, bit RA is excluded from selection while other bits remain; it is emitted last.
  - Encoding: {LW or SW, i, RA, imm6}. imm6 = ADDR_STRIDE × popcount(orig_mask[i-1:0]), unsigned and zero-extended. Offsets follow ascending register order regardless of emission order.
  - When the final micro-op is emitted: out_last=1 and the state returns to IDLE, or to WB when the writeback feature is active.
- WB state (writeback feature only): on a free slot, emit {0000, RA, RA, ADDI}. ADDI = ADDR_STRIDE × popcount(orig_mask), maximum 24. This op carries out_last=1; the preceding micro-op then has out_last=0. Return to IDLE.
- busy = (state != IDLE).
- flush: state to IDLE, pend_mask to 0, out_valid to 0. Flush takes priority over every other event in the same cycle.
- Reset values: state IDLE, out_valid 0, out_inst 16'h0000, out_last 0, all latched registers 0.

## Timing
- Pass-through latency: 1 cycle from acceptance to out_valid.
- Expansion: the first micro-op appears 2 cycles after LM/SM acceptance (accept cycle, then EXPAND emit).
- With no backpressure, expansion runs at one micro-op per cycle. N set bits occupy the output for N cycles, or N+1 with WB.
- The next fetch word is accepted in the cycle after the final op is emitted, provided the slot is free.
- Backpressure rules while out_ready is low: out_inst, out_valid and out_last are held, pend_mask is frozen, and no selection advances.
- Reset asserted mid-expansion clears all state immediately; no partial op is emitted after release.

## Configuration
- LMSM_BASE_WB_EN:
  - Defined: the WB state exists and emits the base post-increment ADI after each non-empty LM/SM. WB is skipped when the instruction is LM and RA is in its mask, because the loaded value wins.
  - Undefined: there is no WB state, and the last LW/SW returns directly to IDLE.

## Test plan
- Pass-through: in 0x1298 with out_ready=1 → out_inst=0x1298, out_valid=1, out_last=1 next cycle; busy stays 0.
- LM R1 mask 0x25 (0x6225), WB off → 0x4040, 0x4442, 0x4A44 on consecutive cycles; out_last on the third only; in_ready low until the cycle after.
- LM R1 mask 0x06 (0x6206), WB on → 0x4442, then 0x4240 with out_last=1; no ADI emitted.
- SM R3 mask 0xFF (0x76FF), WB on, out_ready toggling 1/0 → 0x50C0 … 0x5ECE, then 0x06D0; each value is held stable while out_ready=0; 9 ops total.
- Zero mask 0x6200 → consumed in 1 cycle, no out_valid; the following 0x1298 appears normally.
- Mid-expansion events:
  - flush on the 2nd micro-op of 0x76FF → out_valid=0 next cycle, in_ready=1, busy=0.
  - rst_n pulled low at the same point → all outputs reset asynchronously.

Source files
------------

// File: rtl/lmsm_expander.sv
// lmsm_expander: passes ordinary instructions through a one-entry output register and
// expands LM/SM into LW/SW micro-ops. Define LMSM_BASE_WB_EN to add the base post-increment ADI.
module lmsm_expander #(
   parameter int ADDR_STRIDE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [15:0] in_inst,
   output logic        in_ready,
   output logic        out_valid,
   output logic [15:0] out_inst,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   // Handshake: a word transfers on a rising edge where valid && ready; a producer holding
   // valid keeps its payload stable until that edge, and ready never depends on valid.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_WB     = 2'd2
   } state_t;

   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [5:0] STRIDE = 6'(ADDR_STRIDE);

   state_t      state_q, state_d;
   logic [2:0]  ra_q, ra_d;
   logic        is_sm_q, is_sm_d;
   logic        ra_in_mask_q, ra_in_mask_d;
   logic [7:0]  orig_mask_q, orig_mask_d;
   logic [7:0]  pend_mask_q, pend_mask_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_inst_q, out_inst_d;
   logic        out_last_q, out_last_d;

   logic        slot_free;
   logic        accept;
   logic        in_is_mult;
   logic [7:0]  in_mask;
   logic [7:0]  ra_bit;
   logic [7:0]  cand;
   logic [2:0]  sel_idx;
   logic [7:0]  sel_bit;
   logic [7:0]  pend_after;
   logic        last_op;
   logic [5:0]  below_cnt;
   logic [15:0] micro_op;
   logic        wb_pending;

   assign slot_free  = !out_valid_q || out_ready;
   assign in_ready   = (state_q == S_IDLE) && slot_free && !flush;
   assign accept     = in_valid && in_ready;
   assign in_is_mult = (in_inst[15:13] == 3'b011);
   assign in_mask    = in_inst[7:0];
   assign ra_bit     = 8'b1 << ra_q;

   // LM keeps its base register for last so the address base survives the other loads.
   always_comb begin
      cand = pend_mask_q;
      if (!is_sm_q && ra_in_mask_q && ((pend_mask_q & ~ra_bit) != 8'd0)) begin
         cand = pend_mask_q & ~ra_bit;
      end
      sel_idx = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         if (cand[j]) sel_idx = 3'(j);
      end
      below_cnt = 6'd0;
      for (int j = 0; j < 8; j++) begin
         if (j < int'(sel_idx)) below_cnt = below_cnt + 6'(orig_mask_q[j]);
      end
   end

   assign sel_bit    = 8'b1 << sel_idx;
   assign pend_after = pend_mask_q & ~sel_bit;
   assign last_op    = (pend_after == 8'd0);
   assign micro_op   = {(is_sm_q ? OP_SW : OP_LW), sel_idx, ra_q, below_cnt * STRIDE};

`ifdef LMSM_BASE_WB_EN
   logic [5:0]  total_cnt;
   logic [15:0] wb_op;

   always_comb begin
      total_cnt = 6'd0;
      for (int j = 0; j < 8; j++) begin
         total_cnt = total_cnt + 6'(orig_mask_q[j]);
      end
   end

   // A loaded base register overrides any post-increment.
   assign wb_pending = !(!is_sm_q && ra_in_mask_q);
   assign wb_op      = {4'b0000, ra_q, ra_q, total_cnt * STRIDE};
`else
   assign wb_pending = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept && in_is_mult && (in_mask != 8'd0)) state_d = S_EXPAND;
            end
            S_EXPAND: begin
               if (slot_free && last_op) state_d = wb_pending ? S_WB : S_IDLE;
            end
`ifdef LMSM_BASE_WB_EN
            S_WB: begin
               if (slot_free) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_inst_d   = out_inst_q;
      out_last_d   = out_last_q;
      ra_d         = ra_q;
      is_sm_d      = is_sm_q;
      ra_in_mask_d = ra_in_mask_q;
      orig_mask_d  = orig_mask_q;
      pend_mask_d  = pend_mask_q;
      if (flush) begin
         out_valid_d = 1'b0;
         pend_mask_d = 8'd0;
      end else begin
         if (out_valid_q && out_ready) out_valid_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (!in_is_mult) begin
                     out_valid_d = 1'b1;
                     out_inst_d  = in_inst;
                     out_last_d  = 1'b1;
                  end else if (in_mask != 8'd0) begin
                     ra_d         = in_inst[11:9];
                     is_sm_d      = in_inst[12];
                     ra_in_mask_d = !in_inst[12] && in_mask[in_inst[11:9]];
                     orig_mask_d  = in_mask;
                     pend_mask_d  = in_mask;
                  end
               end
            end
            S_EXPAND: begin
               if (slot_free) begin
                  out_valid_d = 1'b1;
                  out_inst_d  = micro_op;
                  out_last_d  = last_op && !wb_pending;
                  pend_mask_d = pend_after;
               end
            end
`ifdef LMSM_BASE_WB_EN
            S_WB: begin
               if (slot_free) begin
                  out_valid_d = 1'b1;
                  out_inst_d  = wb_op;
                  out_last_d  = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_inst_q   <= 16'h0000;
         out_last_q   <= 1'b0;
         ra_q         <= 3'd0;
         is_sm_q      <= 1'b0;
         ra_in_mask_q <= 1'b0;
         orig_mask_q  <= 8'd0;
         pend_mask_q  <= 8'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_inst_q   <= out_inst_d;
         out_last_q   <= out_last_d;
         ra_q         <= ra_d;
         is_sm_q      <= is_sm_d;
         ra_in_mask_q <= ra_in_mask_d;
         orig_mask_q  <= orig_mask_d;
         pend_mask_q  <= pend_mask_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lmsm_expander.sv
// Directed bench for lmsm_expander; expectations follow the LMSM_BASE_WB_EN build setting.
`timescale 1ns/1ps
module tb_lmsm_expander;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_inst = 16'h0000;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_inst;
   logic        out_last;
   logic        busy;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];

`ifdef LMSM_BASE_WB_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   always #5 clk = ~clk;

   lmsm_expander #(.ADDR_STRIDE(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
      .out_valid(out_valid), .out_inst(out_inst), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
   );

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Holds in_inst valid until accepted; returns on the negedge after the accepting edge.
   task automatic send(input logic [15:0] inst);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_inst  = inst;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (in_ready) done = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_accept inst=%h not accepted within 40 cycles", inst);
      end
   endtask

   // Consumes outputs against exp_q, optionally toggling out_ready, checking holds on stalls.
   task automatic drain(input int max_cycles, input bit toggle);
      bit          prev_stall = 1'b0;
      logic [15:0] prev_inst = 16'h0000;
      logic        prev_last = 1'b0;
      logic [16:0] exp;
      for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
         out_ready = toggle ? (c % 2 == 0) : 1'b1;
         #1;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_inst !== prev_inst || out_last !== prev_last) begin
               errors++;
               $display("FAIL hold got v=%b inst=%h last=%b exp v=1 inst=%h last=%b",
                        out_valid, out_inst, out_last, prev_inst, prev_last);
            end
         end
         if (out_valid && out_ready) begin
            exp = exp_q.pop_front();
            checks++;
            if ({out_last, out_inst} !== exp) begin
               errors++;
               $display("FAIL drain_op got last=%b inst=%h exp last=%b inst=%h",
                        out_last, out_inst, exp[16], exp[15:0]);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_inst  = out_inst;
         prev_last  = out_last;
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout %0d ops still expected", exp_q.size());
      end
      exp_q.delete();
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_inst !== 16'h0000 || out_last !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b inst=%h last=%b busy=%b st=%0d exp 0/0000/0/0/0",
                  out_valid, out_inst, out_last, busy, dbg_state);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_pass_through();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = 16'h1298;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL pass_in_ready got %b exp 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 16'h1298 || out_last !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL pass_out got v=%b inst=%h last=%b busy=%b exp 1/1298/1/0",
                  out_valid, out_inst, out_last, busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pass_drained got out_valid=%b exp 0", out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = 16'h1298;
      @(negedge clk);
      in_inst = 16'h2345;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_inst !== 16'h1298 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got ready=%b v=%b inst=%h exp 1/1/1298", in_ready, out_valid, out_inst);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 16'h2345 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got v=%b inst=%h last=%b exp 1/2345/1", out_valid, out_inst, out_last);
      end
      @(negedge clk);
   endtask

   task automatic test_lm_basic();
      // LM R1 mask 0x25: registers 0,2,5 at offsets 0,2,4.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = 16'h6225;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL lm_accept got in_ready=%b exp 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL lm_accept_cycle got busy=%b v=%b ready=%b exp 1/0/0", busy, out_valid, in_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 16'h4040 || out_last !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL lm_op0 got v=%b inst=%h last=%b ready=%b exp 1/4040/0/0", out_valid, out_inst, out_last, in_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 16'h4442 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL lm_op1 got v=%b inst=%h last=%b exp 1/4442/0", out_valid, out_inst, out_last);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 16'h4A44 || out_last !== !WB || busy !== WB || in_ready !== !WB) begin
         errors++;
         $display("FAIL lm_op2 got v=%b inst=%h last=%b busy=%b ready=%b exp 1/4a44/%b/%b/%b",
                  out_valid, out_inst, out_last, busy, in_ready, !WB, WB, !WB);
      end
      if (WB) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_inst !== 16'h0246 || out_last !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lm_wb got v=%b inst=%h last=%b busy=%b ready=%b exp 1/0246/1/0/1",
                     out_valid, out_inst, out_last, busy, in_ready);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL lm_idle got v=%b busy=%b exp 0/0", out_valid, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_lm_base_in_mask();
      // LM R1 mask 0x06: R2 first, base R1 last, never a writeback.
      out_ready = 1'b1;
      send(16'h6206);
      exp_q.push_back({1'b0, 16'h4442});
      exp_q.push_back({1'b1, 16'h4240});
      drain(20, 1'b0);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL lm_base_after got v=%b busy=%b exp 0/0", out_valid, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_sm_backpressure();
      // SM R3 mask 0xFF: SW Ri,R3,2*i for i=0..7, plus ADI R3,R3,16 with writeback.
      out_ready = 1'b1;
      send(16'h76FF);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({(i == 7) && !WB, 16'h50C0 | (16'(i) << 9) | 16'(2 * i)});
      end
      if (WB) exp_q.push_back({1'b1, 16'h06D0});
      drain(60, 1'b1);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL sm_after got v=%b busy=%b ready=%b exp 0/0/1", out_valid, busy, in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_mask();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = 16'h6200;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_accept got in_ready=%b exp 1", in_ready);
      end
      @(negedge clk);
      in_inst = 16'h1298;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_consumed got v=%b busy=%b ready=%b exp 0/0/1", out_valid, busy, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 16'h1298 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL zero_next got v=%b inst=%h last=%b exp 1/1298/1", out_valid, out_inst, out_last);
      end
      @(negedge clk);
   endtask

   // Starts SM R3 mask 0xFF and returns on the negedge where the 2nd micro-op is visible.
   task automatic start_sm_to_second();
      out_ready = 1'b1;
      send(16'h76FF);
      @(negedge clk);
      #1;
      checks++;
      if (out_inst !== 16'h50C0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_first got v=%b inst=%h exp 1/50c0", out_valid, out_inst);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_inst !== 16'h52C2 || out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_second got v=%b inst=%h busy=%b exp 1/52c2/1", out_valid, out_inst, busy);
      end
   endtask

   task automatic test_flush_mid();
      start_sm_to_second();
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready got in_ready=%b exp 0", in_ready);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL flush_state got v=%b busy=%b ready=%b st=%0d exp 0/0/1/0", out_valid, busy, in_ready, dbg_state);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_quiet got v=%b exp 0", out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      start_sm_to_second();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_inst !== 16'h0000 || out_last !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got v=%b inst=%h last=%b busy=%b exp 0/0000/0/0", out_valid, out_inst, out_last, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release cycle=%0d got v=%b busy=%b exp 0/0", c, out_valid, busy);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_back_to_back();
      test_lm_basic();
      test_lm_base_in_mask();
      test_sm_backpressure();
      test_zero_mask();
      test_flush_mid();
      test_pass_through();
      test_reset_mid();
      test_pass_through();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
